mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Line-granular backing store that answers one L2 memory request at a time.
// Latency: response pulse LATENCY cycles after accept; store write and load data capture occur on that edge.
// Backpressure: no queueing; one transaction outstanding, next accepted only after mem_req_valid drops.
module mem_responder #(
  parameter int LG_DEPTH     = 10,
  parameter int LATENCY      = 4,
  parameter int M_WIDTH      = 32,
  parameter int LG_L2_CL_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req_valid,
  input  logic [M_WIDTH-1:0] mem_req_addr,
  input  logic [3:0]         mem_req_opcode,
  input  logic [127:0]       mem_req_store_data,
  output logic               mem_rsp_valid,
  output logic [127:0]       mem_rsp_load_data,
  output logic               ready,
  output logic [63:0]        num_loads,
  output logic [63:0]        num_stores,
  output logic               bad_op
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [3:0] MEM_LW = 4'd4;
  localparam logic [3:0] MEM_SW = 4'd7;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT_LAT, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [LG_DEPTH-1:0]  init_idx_q, init_idx_d;
  logic [LG_DEPTH-1:0]  idx_q, idx_d;
  logic [3:0]           op_q, op_d;
  logic [127:0]         wdat_q, wdat_d;
  logic [7:0]           lat_cnt_q, lat_cnt_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [127:0]         rsp_dat_q, rsp_dat_d;
  logic [63:0]          loads_q, loads_d;
  logic [63:0]          stores_q, stores_d;
  logic                 bad_q, bad_d;

  logic [127:0]         mem_q [DEPTH];
  logic                 mem_we;
  logic [LG_DEPTH-1:0]  mem_waddr;
  logic [127:0]         mem_wdat;

  // Line index: byte offset bits below and alias bits above are dropped.
  // M_WIDTH must be wider than LG_DEPTH+LG_L2_CL_LEN.
  logic [LG_DEPTH-1:0]  req_idx;
  logic                 unused_addr_bits;
  assign req_idx = mem_req_addr[LG_DEPTH+LG_L2_CL_LEN-1:LG_L2_CL_LEN];
  assign unused_addr_bits = ^{mem_req_addr[M_WIDTH-1:LG_DEPTH+LG_L2_CL_LEN],
                              mem_req_addr[LG_L2_CL_LEN-1:0]};

  // Next-state, transaction bookkeeping and store write port.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    idx_d      = idx_q;
    op_d       = op_q;
    wdat_d     = wdat_q;
    lat_cnt_d  = lat_cnt_q;
    rsp_vld_d  = 1'b0;
    rsp_dat_d  = rsp_dat_q;
    loads_d    = loads_q;
    stores_d   = stores_q;
    bad_d      = bad_q;
    mem_we     = 1'b0;
    mem_waddr  = idx_q;
    mem_wdat   = wdat_q;

    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_idx_q;
        mem_wdat   = '0;
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mem_req_valid) begin
          idx_d     = req_idx;
          op_d      = mem_req_opcode;
          wdat_d    = mem_req_store_data;
          lat_cnt_d = LAT_LOAD;
          state_d   = S_WAIT_LAT;
        end
      end
      S_WAIT_LAT: begin
        if (lat_cnt_q == 8'd0) begin
          rsp_vld_d = 1'b1;
          state_d   = S_DRAIN;
          case (op_q)
            MEM_LW: begin
              rsp_dat_d = mem_q[idx_q];
              loads_d   = loads_q + 64'd1;
            end
            MEM_SW: begin
              mem_we   = 1'b1;
              stores_d = stores_q + 64'd1;
            end
            default: begin
              rsp_dat_d = '0;
              bad_d     = 1'b1;
            end
          endcase
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      S_DRAIN: begin
        // The requester's valid from the finished transaction must fall first.
        if (!mem_req_valid) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // A reset edge discards any write that would have landed on it.
    if (!reset) mem_we = 1'b0;
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      idx_q      <= '0;
      op_q       <= '0;
      wdat_q     <= '0;
      lat_cnt_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      loads_q    <= '0;
      stores_q   <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      wdat_q     <= wdat_d;
      lat_cnt_q  <= lat_cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      loads_q    <= loads_d;
      stores_q   <= stores_d;
      bad_q      <= bad_d;
    end
  end

  // Backing store; contents are cleared by the init sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdat;
  end

  assign mem_rsp_valid     = rsp_vld_q;
  assign mem_rsp_load_data = rsp_dat_q;
  assign ready             = (state_q != S_INIT);
  assign num_loads         = loads_q;
  assign num_stores        = stores_q;
  assign bad_op            = bad_q;

endmodule
